// File: rtl/scan_mem_reg_mux.sv
`default_nettype none
// ============================================================================
// Module   : scan_mem_reg_mux
// Brief    : Routes scan read/write requests to the memory or register-bank
//            port, with a timeout-protected memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module scan_mem_reg_mux #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          REG_AW         = 8,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_wen,
  input  logic              scan_ren,
  input  logic [14:0]       scan_addr,
  input  logic [31:0]       scan_wdata,
  output logic [31:0]       scan_rdata,
  output logic              scan_ready,
  output logic              scan_err,
  output logic              busy,
  output logic              drop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [13:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              reg_wen,
  output logic              reg_ren,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REG_ACC  = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_UNMAP    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;
  logic               r_we;
  logic [13:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_ready, r_busy, r_drop, r_mem_req, r_reg_wen, r_reg_ren;
  logic               w_req, w_accept, w_reg_hit, w_we_nxt;

  always_comb begin
    w_req       = scan_wen | scan_ren;
    w_reg_hit   = ((scan_addr[13:0] >> REG_AW) == '0);
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = '0;
          if (!scan_addr[14])  w_state_nxt = S_MEM_REQ;
          else if (w_reg_hit)  w_state_nxt = S_REG_ACC;
          else                 w_state_nxt = S_UNMAP;
        end
      end
      S_REG_ACC: begin
        w_state_nxt = S_DONE;
        w_err_nxt   = 1'b0;
        if (!r_we) w_rdata_nxt = reg_rdata;
      end
      S_UNMAP: begin
        w_state_nxt = S_DONE;
        w_err_nxt   = 1'b1;
        if (!r_we) w_rdata_nxt = ERR_DATA;
      end
      S_MEM_REQ: begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
        // A read grant on the final cycle leaves no room for data, so it aborts
        if (mem_gnt && r_we) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
          if (!r_we) w_rdata_nxt = ERR_DATA;
        end else if (mem_gnt) begin
          w_state_nxt = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
        if (mem_rvalid) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = mem_rdata;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = ERR_DATA;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_we_nxt = w_accept ? scan_wen : r_we;
  end

  // Strobes are derived from the next state so every output is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
      r_mem_req <= 1'b0;
      r_reg_wen <= 1'b0;
      r_reg_ren <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_drop    <= w_req && (r_state != S_IDLE);
      r_mem_req <= (w_state_nxt == S_MEM_REQ);
      r_reg_wen <= (w_state_nxt == S_REG_ACC) && w_we_nxt;
      r_reg_ren <= (w_state_nxt == S_REG_ACC) && !w_we_nxt;
      if (w_accept) begin
        r_we    <= scan_wen;
        r_addr  <= scan_addr[13:0];
        r_wdata <= scan_wdata;
      end
    end
  end

  assign scan_rdata = r_rdata;
  assign scan_ready = r_ready;
  assign scan_err   = r_err;
  assign busy       = r_busy;
  assign drop       = r_drop;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign reg_wen    = r_reg_wen;
  assign reg_ren    = r_reg_ren;
  assign reg_addr   = r_addr[REG_AW-1:0];
  assign reg_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: doc/scan_mem_reg_mux.md
Name: scan_mem_reg_mux

Overview:
- Downstream stage of the scan read/write controller. Consumes its registered single-cycle scan_wen/scan_ren/scan_addr/scan_wdata request.
- Decodes the 15-bit scan address into the on-chip memory port or the register-bank port, runs the access handshake and returns one scan_ready pulse with scan_rdata.
- Memory accesses are timeout-protected, so the scan path never hangs.

Parameters:
- TIMEOUT_CYCLES, 64, cycles in MEM_REQ+MEM_WAIT before the access is aborted (≥2).
- REG_AW, 8, register-bank address width (1..13).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or unmapped access.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- scan_wen  in  1  write request pulse
- scan_ren  in  1  read request pulse
- scan_addr  in  15  [14]=0 memory, [14]=1 register space
- scan_wdata  in  32  write data
- scan_rdata  out  32  read data, valid when scan_ready=1, held afterwards
- scan_ready  out  1  one-cycle completion pulse
- scan_err  out  1  qualifies scan_ready: 1 = timeout/unmapped; held until next completion
- busy  out  1  high while state≠IDLE
- drop  out  1  one-cycle pulse: request arrived while busy and was discarded
- mem_req  out  1  memory request, held until mem_gnt or timeout
- mem_we  out  1  1=write
- mem_addr  out  14  scan_addr[13:0]
- mem_wdata  out  32  write data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- mem_rdata  in  32  read data
- reg_wen  out  1  one-cycle register write strobe
- reg_ren  out  1  one-cycle register read strobe
- reg_addr  out  REG_AW  scan_addr[REG_AW-1:0]
- reg_wdata  out  32  write data
- reg_rdata  in  32  valid the cycle reg_ren is high

Behaviour:
- Reset: all outputs 0, scan_rdata=0, state=IDLE, timeout counter=0.
- All outputs are registered.
- A request is scan_wen|scan_ren at a clock edge. Accepted only in IDLE.
- Both strobes high: treated as a write only, no read occurs, and scan_rdata is left unchanged.
- Request in any state other than IDLE: discarded, drop=1 the next cycle, no other effect.
- Decode of an accepted request:
  - addr[14]=0 → MEM_REQ.
  - addr[14]=1 and addr[13:REG_AW]==0 → REG_ACC.
  - otherwise unmapped → DONE with err=1. A read gets rdata=ERR_DATA; a write has no side effect.
- Address, data and we are latched at acceptance and held stable on the mem_/reg_ outputs until the next acceptance.
- REG_ACC (1 cycle): reg_wen or reg_ren =1. On a read, reg_rdata is captured at the end of the cycle → DONE.
- MEM_REQ: mem_req=1.
  - mem_gnt & write → DONE.
  - mem_gnt & read → MEM_WAIT, mem_req drops the next cycle.
- MEM_WAIT: mem_rvalid → capture mem_rdata → DONE.
- Timeout: the counter increments every cycle in MEM_REQ/MEM_WAIT and clears on acceptance.
  - Reaching TIMEOUT_CYCLES-1 without completion → abort: mem_req=0, DONE with err=1 (reads get rdata=ERR_DATA).
  - A completion event on the same edge as the timeout wins: normal completion, err=0.
- DONE (1 cycle): scan_ready=1, scan_err valid → IDLE. A request coincident with DONE is dropped.
- Latency from request edge T (request sampled at T):
  - Register access: strobe in cycle T+1, scan_ready in cycle T+2.
  - Memory write with immediate gnt: mem_req in cycle T+1, scan_ready in cycle T+2.
  - Memory read: scan_ready the cycle after mem_rvalid.
- mem_rvalid/mem_gnt outside the states that expect them: ignored.
- Reset asserted mid-access: immediate return to IDLE, all strobes deasserted, no scan_ready.

Test Plan:
- Reg write addr=15'h4012, wdata=32'h1234_5678 → reg_wen=1 with reg_addr=8'h12 at T+1; scan_ready=1, scan_err=0 at T+2.
- Reg read addr=15'h40FF, reg_rdata=32'hCAFE_0001 → reg_ren at T+1; scan_ready at T+2 with scan_rdata=32'hCAFE_0001.
- Mem read addr=15'h0123, gnt after 3 cycles, rvalid 2 cycles later with 32'h0BAD_F00D → mem_addr=14'h0123, mem_req drops after gnt, scan_ready one cycle after rvalid with correct data and err=0.
- Mem read, no gnt ever (TIMEOUT_CYCLES=64) → mem_req high for 64 cycles then 0; scan_ready with scan_rdata=32'hDEAD_BEEF, scan_err=1.
- Unmapped read addr=15'h7F00 (REG_AW=8) → no mem/reg strobes; scan_ready at T+2 with ERR_DATA, err=1.
- Second request 2 cycles into a pending mem access → drop=1 for one cycle; the original access completes normally; only one scan_ready. Also pulse rst_n low mid-MEM_WAIT → all outputs 0, no scan_ready.
